// File: rtl/ctrl_skew_stream_pkg.sv
// Shared types and helpers for the skew/deskew wavefront stage.
package ctrl_skew_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam logic MODE_SKEW   = 1'b0;
  localparam logic MODE_DESKEW = 1'b1;

  // Skew delays the low lanes most; deskew undoes a skew by delaying the high lanes most.
  function automatic int unsigned lane_delay(int unsigned lane, int unsigned lanes, logic mode);
    return (mode == MODE_DESKEW) ? lane : lanes - 1 - lane;
  endfunction

endpackage

// File: rtl/ctrl_skew_stream_lane.sv
// One lane: an enabled shift register of {valid, data} with a runtime-selected tap.
module skew_lane #(
  parameter int W     = 9,
  parameter int DEPTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [W-1:0]                 din,
  input  logic [$clog2(DEPTH+1)-1:0]   tap,
  output logic [W-1:0]                 dout
);

  localparam int TAP_W = $clog2(DEPTH + 1);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    for (int k = 0; k < DEPTH; k++) stage_d[k] = stage_q[k];
    if (en) begin
      stage_d[0] = din;
      for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the stages are reset (not left as plain storage) because the valid bit rides in them.
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
    end
  end

  always_comb begin
    dout = din;
    for (int k = 1; k <= DEPTH; k++) begin
      if (tap == TAP_W'(k)) dout = stage_q[k-1];
    end
  end

endmodule

// File: rtl/ctrl_skew_stream.sv
// Row <-> diagonal wavefront converter with per-lane valid, stall and drain/done tracking.
module ctrl_skew_stream
  import ctrl_skew_stream_pkg::*;
#(
  parameter int DATA_BW = 8,
  parameter int LANES   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic                       stall,
  input  logic                       in_valid,
  input  logic [DATA_BW*LANES-1:0]   data_in,
  output logic [DATA_BW*LANES-1:0]   data_out,
  output logic [LANES-1:0]           out_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int W     = DATA_BW + 1;
  localparam int CNT_W = $clog2(LANES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [W-1:0]     hold_q, hold_d;
  logic             done_c;
  logic             eff_mode;
  logic [W-1:0]     lane_in [LANES];

  assign eff_mode = (state_q == IDLE) ? mode : mode_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int DEPTH = (LANES - 1 - i > i) ? LANES - 1 - i : i;
    localparam int TAP_W = $clog2(DEPTH + 1);

    logic [TAP_W-1:0] tap;
    logic [W-1:0]     lane_out;
    logic [W-1:0]     sel;

    assign lane_in[i] = in_valid ? {1'b1, data_in[DATA_BW*i +: DATA_BW]} : '0;
    assign tap        = TAP_W'(lane_delay(i, LANES, eff_mode));

    skew_lane #(.W(W), .DEPTH(DEPTH)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (!stall),
      .din  (lane_in[i]),
      .tap  (tap),
      .dout (lane_out)
    );

    // The pass-through lane has no stage of its own to freeze, so it shows the held copy.
    assign sel = (stall && tap == '0) ? hold_q : lane_out;
    assign data_out[DATA_BW*i +: DATA_BW] = sel[DATA_BW-1:0];
    assign out_valid[i]                   = sel[DATA_BW];
  end

  always_comb begin
    hold_d = hold_q;
    if (!stall) hold_d = (eff_mode == MODE_DESKEW) ? lane_in[0] : lane_in[LANES-1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_c  = 1'b0;
    if (!stall) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d = STREAM;
            mode_d  = mode;
          end
        end
        STREAM: begin
          // With two lanes the tail clears in the very cycle the stream stops.
          if (!in_valid) begin
            if (LANES == 2) begin
              done_c  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DRAIN;
              cnt_d   = CNT_W'(LANES - 1);
            end
          end
        end
        DRAIN: begin
          if (in_valid) begin
            state_d = STREAM;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(2)) begin
            done_c  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_SKEW;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_c && !rst;

endmodule

// File: tb/tb_ctrl_skew_stream.sv
// Randomised and directed bench for ctrl_skew_stream against a history-based reference model.
module tb_ctrl_skew_stream;

  localparam int L  = 4;
  localparam int BW = 8;

  logic            clk = 1'b0;
  logic            rst, mode, stall, in_valid;
  logic [BW*L-1:0] data_in, data_out;
  logic [L-1:0]    out_valid;
  logic            busy, done;

  always #5 clk = ~clk;

  ctrl_skew_stream #(.DATA_BW(BW), .LANES(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .stall     (stall),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Model: every accepted (non-stalled) cycle appends its gated row to a history since reset.
  logic            hv [$];
  logic [BW*L-1:0] hd [$];
  bit              active   = 1'b0;
  logic            mode_lat = 1'b0;
  int              lastk    = -1;
  logic            cur_mode = 1'b0;

  function automatic logic [BW:0] entry(int j, int lane);
    if (j < 0 || j >= hv.size()) return '0;
    return {hv[j], hd[j][BW*lane +: BW]};
  endfunction

  task automatic step(input logic r, input logic s, input logic m, input logic iv,
                      input logic [BW*L-1:0] din);
    logic            eff, exp_done;
    logic [BW*L-1:0] exp_do;
    logic [L-1:0]    exp_ov;
    logic [BW:0]     e;
    int              n, d;
    rst = r; stall = s; mode = m; in_valid = iv; data_in = din;
    @(negedge clk);
    n   = hv.size();
    eff = active ? mode_lat : m;
    for (int i = 0; i < L; i++) begin
      d = eff ? i : L - 1 - i;
      if (d == 0 && !s)  e = iv ? {1'b1, din[BW*i +: BW]} : '0;
      else if (d == 0)   e = entry(n - 1, i);
      else               e = entry(n - d, i);
      exp_ov[i]           = e[BW];
      exp_do[BW*i +: BW]  = e[BW-1:0];
    end
    exp_done = !r && !s && !iv && active && lastk >= 0 && (n - lastk == L - 1);
    check("data_out",  64'(data_out),  64'(exp_do));
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    check("busy",      64'(busy),      64'(active));
    check("done",      64'(done),      64'(exp_done));
    @(posedge clk);
    #1;
    if (r) begin
      hv.delete(); hd.delete();
      active = 1'b0; mode_lat = 1'b0; lastk = -1;
    end else if (!s) begin
      hv.push_back(iv);
      hd.push_back(iv ? din : '0);
      if (iv) begin
        if (!active) begin
          active   = 1'b1;
          mode_lat = m;
        end
        lastk = n;
      end
      if (exp_done) begin
        active = 1'b0;
        lastk  = -1;
      end
    end
  endtask

  function automatic logic [BW*L-1:0] rnd_row();
    logic [BW*L-1:0] v;
    for (int i = 0; i < L; i++) v[BW*i +: BW] = BW'($urandom_range(1, 255));
    return v;
  endfunction

  task automatic idle(input int cycles, input logic m);
    for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, m, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; mode = 1'b0; in_valid = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, including the pass-through lane showing gated data_in.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0a0b0c0d);
    idle(2, 1'b0);

    // Skew: a single row {4,3,2,1}.
    step(1'b0, 1'b0, 1'b0, 1'b1, {8'd4, 8'd3, 8'd2, 8'd1});
    idle(6, 1'b0);

    // Deskew: four consecutive rows.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b1, rnd_row());
    idle(6, 1'b1);

    // Four rows with a two-cycle stall after the second one.
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
    step(1'b0, 1'b1, 1'b0, 1'b1, rnd_row());
    step(1'b0, 1'b1, 1'b0, 1'b0, rnd_row());
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
    idle(6, 1'b0);

    // Gaps: valid, invalid, valid.
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
    step(1'b0, 1'b0, 1'b0, 1'b0, rnd_row());
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
    idle(6, 1'b0);

    // Mode toggled mid-stream is ignored until the drain completes.
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
    step(1'b0, 1'b0, 1'b1, 1'b1, rnd_row());
    step(1'b0, 1'b0, 1'b1, 1'b1, rnd_row());
    idle(6, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, rnd_row());
    idle(6, 1'b1);

    // Reset in the middle of a drain.
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_row());
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(4, 1'b0);

    // Random traffic; mode only moves on non-stalled cycles so a stall never sees a new mode.
    cur_mode = 1'b0;
    for (int k = 0; k < 600; k++) begin
      logic s, r, iv;
      s  = ($urandom_range(0, 99) < 15);
      r  = ($urandom_range(0, 99) < 2);
      iv = ($urandom_range(0, 99) < 55);
      if (!s && $urandom_range(0, 9) == 0) cur_mode = ~cur_mode;
      step(r, s, cur_mode, iv, rnd_row());
    end
    idle(6, cur_mode);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
